// File: rtl/vertex_xform_sequencer.sv
// vertex_xform_sequencer
//   Multi-cycle vertex transform engine sitting between decode and the
//   rasterizer/frame stage. Owns the current 4x4 fixed-point transform
//   matrix M, a push/pop stack of {M, colour}, the colour register and the
//   primitive flag. One 16x16 signed MAC is time-shared between the
//   matrix multiply (M = M*T, 64 MAC cycles + 1 copy cycle) and the
//   vertex transform (6 MAC cycles).
//
// Ports
//   I_CLOCK, I_RESET_N          clock, asynchronous active-low reset
//   I_VALID / O_IN_READY        opcode input handshake
//   I_Opcode, I_VRegIn          opcode and operand (x=[31:16], y=[47:32])
//   I_FRAMESTALL                freezes acceptance, FSM and MAC
//   O_VALID / I_OUT_READY       output beat handshake
//   O_Opcode, O_VOut            opcode and transformed vertex of the beat
//   O_ColorOut                  current colour
//   O_STACK_ERR                 sticky push-overflow / pop-underflow flag
//
// Build option
//   VSEQ_SATURATE_EN : when defined, stored results saturate to
//   16'h7FFF / 16'h8000 instead of wrapping.

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 8
`endif
`ifndef VREG_WIDTH
`define VREG_WIDTH 64
`endif
`ifndef OP_NOP
`define OP_NOP            8'd0
`define OP_LOADIDENTITY   8'd1
`define OP_BEGINPRIMITIVE 8'd2
`define OP_ENDPRIMITIVE   8'd3
`define OP_SETCOLOR       8'd4
`define OP_PUSHMATRIX     8'd5
`define OP_POPMATRIX      8'd6
`define OP_TRANSLATE      8'd7
`define OP_SCALE          8'd8
`define OP_ROTATE         8'd9
`define OP_SETVERTEX      8'd10
`endif

module vertex_xform_sequencer #(
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned FRAC_BITS   = 8
) (
    input  logic                     I_CLOCK,
    input  logic                     I_RESET_N,
    input  logic                     I_VALID,
    output logic                     O_IN_READY,
    input  logic [`OPCODE_WIDTH-1:0] I_Opcode,
    input  logic [`VREG_WIDTH-1:0]   I_VRegIn,
    input  logic                     I_FRAMESTALL,
    output logic                     O_VALID,
    input  logic                     I_OUT_READY,
    output logic [`OPCODE_WIDTH-1:0] O_Opcode,
    output logic [`VREG_WIDTH-1:0]   O_VOut,
    output logic [`VREG_WIDTH-1:0]   O_ColorOut,
    output logic                     O_STACK_ERR
);

    localparam int unsigned SPW = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic signed [15:0] ONE = 16'(1 << FRAC_BITS);

    typedef enum logic [1:0] {IDLE, MATMUL, XFORM, OUT} state_t;

    state_t state, state_next;

    // Matrices are stored row-major: element (r,c) lives at index {r,c}.
    logic signed [15:0] m       [16];
    logic signed [15:0] t       [16];
    logic signed [15:0] scratch [16];
    logic signed [15:0] stk_m   [2**IW][16];
    logic [`VREG_WIDTH-1:0] stk_c [2**IW];

    logic [SPW-1:0]           sp;
    logic [`VREG_WIDTH-1:0]   colour;
    logic                     prim;
    logic                     err;
    logic [`VREG_WIDTH-1:0]   vin;
    logic [6:0]               cnt;
    logic signed [31:0]       acc;
    logic signed [15:0]       xr;
    logic [`OPCODE_WIDTH-1:0] out_op;
    logic [`VREG_WIDTH-1:0]   out_v;

    logic               in_ready;
    logic               accept;
    logic               push_en;
    logic [IW-1:0]      push_idx;
    logic [IW-1:0]      pop_idx;
    logic [1:0]         mi, mj, mk;
    logic signed [15:0] a_op, b_op;
    logic               mac_clr;
    logic signed [31:0] prod;
    logic signed [31:0] acc_sum;
    logic signed [15:0] q;

    function automatic logic signed [15:0] ident_elem(input int unsigned n);
        return (n % 5 == 0) ? ONE : 16'sd0;
    endfunction

    // Window acc[FRAC_BITS+15:FRAC_BITS]; the arithmetic shift rounds toward -inf.
    function automatic logic signed [15:0] quantize(input logic signed [31:0] a);
        logic signed [31:0] sh;
        sh = a >>> FRAC_BITS;
`ifdef VSEQ_SATURATE_EN
        if (sh > 32'sd32767)  return 16'sh7FFF;
        if (sh < -32'sd32768) return 16'sh8000;
`endif
        return 16'(sh);
    endfunction

    assign in_ready   = I_RESET_N && (state == IDLE) && !O_VALID && !I_FRAMESTALL;
    assign accept     = I_VALID && in_ready;
    assign O_IN_READY = in_ready;
    assign O_VALID    = (state == OUT);
    assign O_Opcode   = out_op;
    assign O_VOut     = out_v;
    assign O_ColorOut = colour;
    assign O_STACK_ERR = err;

    assign push_en  = accept && (I_Opcode == `OP_PUSHMATRIX) && (sp != SPW'(STACK_DEPTH));
    assign push_idx = IW'(sp);
    assign pop_idx  = IW'(sp - 1'b1);

    // MATMUL walks cnt[5:0] as {i,j,k} with k innermost.
    assign mi = cnt[5:4];
    assign mj = cnt[3:2];
    assign mk = cnt[1:0];

    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) state <= IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (I_Opcode)
                        `OP_TRANSLATE, `OP_SCALE, `OP_ROTATE: state_next = MATMUL;
                        `OP_SETVERTEX: state_next = prim ? XFORM : IDLE;
                        default:       state_next = OUT;
                    endcase
                end
            end
            MATMUL: if (!I_FRAMESTALL && cnt == 7'd64) state_next = OUT;
            XFORM:  if (!I_FRAMESTALL && cnt == 7'd5)  state_next = OUT;
            OUT:    if (I_OUT_READY)                   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shared MAC operand selection.
    always_comb begin
        a_op    = 16'sd0;
        b_op    = 16'sd0;
        mac_clr = 1'b0;
        case (state)
            MATMUL: begin
                a_op    = m[{mi, mk}];
                b_op    = t[{mk, mj}];
                mac_clr = (mk == 2'd0);
            end
            XFORM: begin
                case (cnt[2:0])
                    3'd0: begin a_op = m[0]; b_op = $signed(vin[31:16]); mac_clr = 1'b1; end
                    3'd1: begin a_op = m[1]; b_op = $signed(vin[47:32]); end
                    3'd2: begin a_op = m[3]; b_op = ONE; end
                    3'd3: begin a_op = m[4]; b_op = $signed(vin[31:16]); mac_clr = 1'b1; end
                    3'd4: begin a_op = m[5]; b_op = $signed(vin[47:32]); end
                    3'd5: begin a_op = m[7]; b_op = ONE; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign prod    = a_op * b_op;
    assign acc_sum = (mac_clr ? 32'sd0 : acc) + prod;
    assign q       = quantize(acc_sum);

    // Stack storage needs no reset: entries are only read below sp.
    always_ff @(posedge I_CLOCK) begin
        if (push_en) begin
            for (int unsigned n = 0; n < 16; n++) stk_m[push_idx][4'(n)] <= m[4'(n)];
            stk_c[push_idx] <= colour;
        end
    end

    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            for (int unsigned n = 0; n < 16; n++) begin
                m[4'(n)]       <= ident_elem(n);
                t[4'(n)]       <= ident_elem(n);
                scratch[4'(n)] <= 16'sd0;
            end
            sp     <= '0;
            colour <= '0;
            prim   <= 1'b0;
            err    <= 1'b0;
            vin    <= '0;
            cnt    <= '0;
            acc    <= '0;
            xr     <= '0;
            out_op <= '0;
            out_v  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt <= '0;
                        if (!(I_Opcode == `OP_SETVERTEX && !prim)) out_op <= I_Opcode;
                        case (I_Opcode)
                            `OP_LOADIDENTITY: begin
                                for (int unsigned n = 0; n < 16; n++) m[4'(n)] <= ident_elem(n);
                                colour <= '0;
                            end
                            `OP_BEGINPRIMITIVE: prim   <= 1'b1;
                            `OP_ENDPRIMITIVE:   prim   <= 1'b0;
                            `OP_SETCOLOR:       colour <= I_VRegIn;
                            `OP_PUSHMATRIX: begin
                                if (sp == SPW'(STACK_DEPTH)) err <= 1'b1;
                                else                          sp  <= sp + 1'b1;
                            end
                            `OP_POPMATRIX: begin
                                if (sp == '0) begin
                                    err <= 1'b1;
                                end else begin
                                    sp <= sp - 1'b1;
                                    for (int unsigned n = 0; n < 16; n++)
                                        m[4'(n)] <= stk_m[pop_idx][4'(n)];
                                    colour <= stk_c[pop_idx];
                                end
                            end
                            `OP_TRANSLATE: begin
                                for (int unsigned n = 0; n < 16; n++) t[4'(n)] <= ident_elem(n);
                                t[3] <= $signed(I_VRegIn[31:16]);
                                t[7] <= $signed(I_VRegIn[47:32]);
                            end
                            `OP_SCALE: begin
                                for (int unsigned n = 0; n < 16; n++) t[4'(n)] <= ident_elem(n);
                                t[0] <= $signed(I_VRegIn[31:16]);
                                t[5] <= $signed(I_VRegIn[47:32]);
                            end
                            `OP_ROTATE: begin
                                for (int unsigned n = 0; n < 16; n++) t[4'(n)] <= ident_elem(n);
                                t[0] <= $signed(I_VRegIn[31:16]);
                                t[5] <= $signed(I_VRegIn[31:16]);
                                t[1] <= -$signed(I_VRegIn[47:32]);
                                t[4] <= $signed(I_VRegIn[47:32]);
                            end
                            `OP_SETVERTEX: vin <= I_VRegIn;
                            default: ;
                        endcase
                    end
                end
                MATMUL: begin
                    if (!I_FRAMESTALL) begin
                        if (cnt == 7'd64) begin
                            // M is only overwritten here, so an abort leaves it intact.
                            for (int unsigned n = 0; n < 16; n++) m[4'(n)] <= scratch[4'(n)];
                        end else begin
                            acc <= acc_sum;
                            if (mk == 2'd3) scratch[{mi, mj}] <= q;
                            cnt <= cnt + 7'd1;
                        end
                    end
                end
                XFORM: begin
                    if (!I_FRAMESTALL) begin
                        acc <= acc_sum;
                        cnt <= cnt + 7'd1;
                        if (cnt == 7'd2) xr <= q;
                        if (cnt == 7'd5) out_v <= {vin[63:48], q, xr, vin[15:0]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vertex_xform_sequencer.sv
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 8
`endif
`ifndef VREG_WIDTH
`define VREG_WIDTH 64
`endif
`ifndef OP_NOP
`define OP_NOP            8'd0
`define OP_LOADIDENTITY   8'd1
`define OP_BEGINPRIMITIVE 8'd2
`define OP_ENDPRIMITIVE   8'd3
`define OP_SETCOLOR       8'd4
`define OP_PUSHMATRIX     8'd5
`define OP_POPMATRIX      8'd6
`define OP_TRANSLATE      8'd7
`define OP_SCALE          8'd8
`define OP_ROTATE         8'd9
`define OP_SETVERTEX      8'd10
`endif

module tb_vertex_xform_sequencer;

    logic                     I_CLOCK;
    logic                     I_RESET_N;
    logic                     I_VALID;
    logic                     O_IN_READY;
    logic [`OPCODE_WIDTH-1:0] I_Opcode;
    logic [`VREG_WIDTH-1:0]   I_VRegIn;
    logic                     I_FRAMESTALL;
    logic                     O_VALID;
    logic                     I_OUT_READY;
    logic [`OPCODE_WIDTH-1:0] O_Opcode;
    logic [`VREG_WIDTH-1:0]   O_VOut;
    logic [`VREG_WIDTH-1:0]   O_ColorOut;
    logic                     O_STACK_ERR;

    int checks = 0;
    int errors = 0;

    vertex_xform_sequencer #(.STACK_DEPTH(4), .FRAC_BITS(8)) dut (
        .I_CLOCK     (I_CLOCK),
        .I_RESET_N   (I_RESET_N),
        .I_VALID     (I_VALID),
        .O_IN_READY  (O_IN_READY),
        .I_Opcode    (I_Opcode),
        .I_VRegIn    (I_VRegIn),
        .I_FRAMESTALL(I_FRAMESTALL),
        .O_VALID     (O_VALID),
        .I_OUT_READY (I_OUT_READY),
        .O_Opcode    (O_Opcode),
        .O_VOut      (O_VOut),
        .O_ColorOut  (O_ColorOut),
        .O_STACK_ERR (O_STACK_ERR)
    );

    initial I_CLOCK = 1'b0;
    always #5 I_CLOCK = ~I_CLOCK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge I_CLOCK);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] op, input logic [63:0] v);
        int n = 0;
        while (O_IN_READY !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        if (O_IN_READY !== 1'b1) check("in_ready_timeout", 64'(O_IN_READY), 64'd1);
        I_VALID  = 1'b1;
        I_Opcode = op;
        I_VRegIn = v;
        tick(1);
        I_VALID  = 1'b0;
    endtask

    // lat counts the accept edge as 1 and every following edge up to O_VALID.
    task automatic wait_out(input int start, input int limit, output int lat);
        lat = start;
        while (O_VALID !== 1'b1 && lat < limit) begin
            tick(1);
            lat++;
        end
        check("out_valid_seen", 64'(O_VALID), 64'd1);
    endtask

    task automatic drain();
        I_OUT_READY = 1'b1;
        tick(1);
        I_OUT_READY = 1'b0;
    endtask

    task automatic single_op(input string tag, input logic [7:0] op, input logic [63:0] v);
        int lat;
        send(op, v);
        wait_out(1, 10, lat);
        check({tag, "_lat"}, 64'(lat), 64'd1);
        check({tag, "_op"}, 64'(O_Opcode), 64'(op));
        drain();
    endtask

    task automatic mat_op(input string tag, input logic [7:0] op, input logic [15:0] x, input logic [15:0] y);
        int lat;
        send(op, {16'h0, y, x, 16'h0});
        wait_out(1, 200, lat);
        check({tag, "_lat"}, 64'(lat), 64'd66);
        check({tag, "_op"}, 64'(O_Opcode), 64'(op));
        drain();
    endtask

    task automatic vertex(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] ex, input logic [15:0] ey);
        int lat;
        send(`OP_SETVERTEX, {16'hAAAA, y, x, 16'h5555});
        wait_out(1, 40, lat);
        check({tag, "_lat"}, 64'(lat), 64'd7);
        check(tag, O_VOut, {16'hAAAA, ey, ex, 16'h5555});
        drain();
    endtask

    initial begin
        int lat;
        I_RESET_N    = 1'b0;
        I_VALID      = 1'b0;
        I_Opcode     = '0;
        I_VRegIn     = '0;
        I_FRAMESTALL = 1'b0;
        I_OUT_READY  = 1'b0;

        // Reset state
        tick(3);
        check("rst_valid", 64'(O_VALID), 64'd0);
        check("rst_in_ready", 64'(O_IN_READY), 64'd0);
        check("rst_opcode", 64'(O_Opcode), 64'd0);
        check("rst_vout", O_VOut, 64'd0);
        check("rst_color", O_ColorOut, 64'd0);
        check("rst_err", 64'(O_STACK_ERR), 64'd0);
        I_RESET_N = 1'b1;
        tick(1);
        check("post_rst_in_ready", 64'(O_IN_READY), 64'd1);

        // Identity transform inside a primitive
        single_op("begin", `OP_BEGINPRIMITIVE, 64'h0);
        vertex("vx_ident", 16'h0200, 16'h0300, 16'h0200, 16'h0300);

        // Translate
        mat_op("translate", `OP_TRANSLATE, 16'h0100, 16'hFF00);
        vertex("vx_translate", 16'h0200, 16'h0300, 16'h0300, 16'h0200);

        // Scale, then a product that leaves the 16-bit window
        single_op("loadid", `OP_LOADIDENTITY, 64'h0);
        mat_op("scale", `OP_SCALE, 16'h0200, 16'h0080);
        vertex("vx_scale", 16'h0100, 16'h0400, 16'h0200, 16'h0200);
`ifdef VSEQ_SATURATE_EN
        vertex("vx_overflow", 16'h5000, 16'h0000, 16'h7FFF, 16'h0000);
`else
        vertex("vx_overflow", 16'h5000, 16'h0000, 16'hA000, 16'h0000);
`endif

        // Rotate by 90 degrees: cos=0, sin=1.0
        single_op("loadid", `OP_LOADIDENTITY, 64'h0);
        mat_op("rotate", `OP_ROTATE, 16'h0000, 16'h0100);
        vertex("vx_rotate", 16'h0200, 16'h0300, 16'hFD00, 16'h0200);

        // Push / translate / pop restores M
        single_op("loadid", `OP_LOADIDENTITY, 64'h0);
        single_op("push", `OP_PUSHMATRIX, 64'h0);
        mat_op("translate2", `OP_TRANSLATE, 16'h0100, 16'h0000);
        single_op("pop", `OP_POPMATRIX, 64'h0);
        check("err_after_balanced", 64'(O_STACK_ERR), 64'd0);
        vertex("vx_restored", 16'h0100, 16'h0000, 16'h0100, 16'h0000);

        // Underflow: five pops from an empty stack
        single_op("pop_empty", `OP_POPMATRIX, 64'h0);
        check("err_underflow", 64'(O_STACK_ERR), 64'd1);
        repeat (4) single_op("pop_empty", `OP_POPMATRIX, 64'h0);
        check("err_sticky", 64'(O_STACK_ERR), 64'd1);
        vertex("vx_after_underflow", 16'h0200, 16'h0300, 16'h0200, 16'h0300);

        // Vertex outside a primitive is dropped
        single_op("end", `OP_ENDPRIMITIVE, 64'h0);
        send(`OP_SETVERTEX, {16'h1111, 16'h0700, 16'h0700, 16'h2222});
        tick(10);
        check("dropped_valid", 64'(O_VALID), 64'd0);
        check("dropped_in_ready", 64'(O_IN_READY), 64'd1);
        single_op("begin", `OP_BEGINPRIMITIVE, 64'h0);

        // Output held while downstream is not ready
        send(`OP_SETCOLOR, 64'h1122334455667788);
        wait_out(1, 10, lat);
        for (int c = 0; c < 10; c++) begin
            check("hold_vout", O_VOut, 64'hAAAA030002005555);
            check("hold_in_ready", 64'(O_IN_READY), 64'd0);
            tick(1);
        end
        check("hold_color", O_ColorOut, 64'h1122334455667788);
        check("hold_op", 64'(O_Opcode), 64'(`OP_SETCOLOR));
        drain();
        check("drained_valid", 64'(O_VALID), 64'd0);
        single_op("loadid", `OP_LOADIDENTITY, 64'h0);
        check("loadid_color", O_ColorOut, 64'd0);

        // Frame stall mid-MATMUL delays completion by the stall length
        send(`OP_TRANSLATE, {16'h0, 16'h0200, 16'h0100, 16'h0});
        lat = 1;
        tick(10);
        lat += 10;
        I_FRAMESTALL = 1'b1;
        tick(20);
        lat += 20;
        I_FRAMESTALL = 1'b0;
        wait_out(lat, 300, lat);
        check("stall_lat", 64'(lat), 64'd86);
        drain();
        vertex("vx_after_stall", 16'h0100, 16'h0100, 16'h0200, 16'h0300);

        // Reset mid-MATMUL
        single_op("loadid", `OP_LOADIDENTITY, 64'h0);
        send(`OP_TRANSLATE, {16'h0, 16'h0000, 16'h0100, 16'h0});
        tick(30);
        I_RESET_N = 1'b0;
        #1;
        check("abort_valid", 64'(O_VALID), 64'd0);
        check("abort_in_ready", 64'(O_IN_READY), 64'd0);
        check("abort_err", 64'(O_STACK_ERR), 64'd0);
        tick(2);
        I_RESET_N = 1'b1;
        tick(1);
        single_op("begin", `OP_BEGINPRIMITIVE, 64'h0);
        vertex("vx_after_abort", 16'h0200, 16'h0300, 16'h0200, 16'h0300);

        // Overflow: four pushes fit, the fifth flags
        repeat (4) single_op("push_fill", `OP_PUSHMATRIX, 64'h0);
        check("err_full", 64'(O_STACK_ERR), 64'd0);
        single_op("push_over", `OP_PUSHMATRIX, 64'h0);
        check("err_overflow", 64'(O_STACK_ERR), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
